model_convolutional_fnn_vector_transmitter: RTL and testbench
=============================================================

Name: model_convolutional_fnn_vector_transmitter

Overview:
Source-side streamer for the convolutional FNN controller. It buffers one input vector (x or r) written element-by-element, then on START streams it to the controller SIZE_R_IN times, SIZE_I_IN elements per pass. The controller needs the vector re-read once per weight-matrix row. Transfers use the controller's element handshake (DATA_OUT_ENABLE valid, DATA_IN_ENABLE accept).

Parameters:
DATA_SIZE, 64, element width in bits.
CONTROL_SIZE, 64, width of size and index fields.
LENGTH, 64, buffer depth in elements (matches L).

Ports:
CLK  input  1  clock; all logic on rising edge.
RST  input  1  synchronous reset, active-low.
WRITE_ENABLE  input  1  buffer write strobe; honoured only in IDLE.
WRITE_INDEX  input  CONTROL_SIZE  buffer write address; writes with index >= LENGTH are dropped.
WRITE_DATA  input  DATA_SIZE  buffer write data.
START  input  1  start request; sampled only in IDLE.
SIZE_I_IN  input  CONTROL_SIZE  elements per pass; latched at START.
SIZE_R_IN  input  CONTROL_SIZE  number of passes; latched at START.
READY  output  1  high while IDLE.
DONE  output  1  one-cycle pulse after the final transfer.
ERROR  output  1  sticky flag for an invalid START.
DATA_OUT_ENABLE  output  1  DATA_OUT valid.
DATA_IN_ENABLE  input  1  consumer accepts the current element.
DATA_OUT  output  DATA_SIZE  current element.
INDEX_OUT  output  CONTROL_SIZE  element index within the pass.
PASS_OUT  output  CONTROL_SIZE  current pass number.
LAST_OUT  output  1  current element is the last of its pass.

Behaviour:
- Reset (RST=0 at a rising edge):
  - State goes to IDLE.
  - READY=1; DONE=0; ERROR=0; DATA_OUT_ENABLE=0; DATA_OUT=0; INDEX_OUT=0; PASS_OUT=0; LAST_OUT=0.
  - All buffer entries are cleared to 0.
  - Reset overrides every other input, including mid-stream.
- States: IDLE and SEND only.
- IDLE:
  - A WRITE_ENABLE with WRITE_INDEX < LENGTH writes the buffer.
  - START with 1 <= SIZE_I_IN <= LENGTH and SIZE_R_IN >= 1: latch both sizes, clear ERROR, zero the counters, go to SEND.
  - START with any other sizes: set ERROR, stay in IDLE, READY stays 1.
  - If WRITE_ENABLE and START arrive in the same cycle, the write is performed and the stream starts with the updated buffer.
- SEND:
  - READY=0 and DATA_OUT_ENABLE=1.
  - DATA_OUT = buffer[INDEX_OUT]. LAST_OUT = (INDEX_OUT == SIZE_I-1).
  - The first element is valid in the cycle after the START edge.
- Transfer: an edge where DATA_OUT_ENABLE=1 and DATA_IN_ENABLE=1.
  - Non-last element: INDEX_OUT increments.
  - Last element of a pass that is not the final pass: INDEX_OUT goes to 0 and PASS_OUT increments.
  - Final transfer (INDEX_OUT = SIZE_I-1 and PASS_OUT = SIZE_R-1): go to IDLE. In the next cycle DATA_OUT_ENABLE=0, READY=1 and DONE=1 for exactly one cycle.
- Throughput and total count:
  - One element per cycle while DATA_IN_ENABLE is held high.
  - Total transfers = SIZE_I*SIZE_R.
  - Busy time = SIZE_I*SIZE_R cycles plus stall cycles.
- Backpressure: while DATA_IN_ENABLE=0, DATA_OUT, INDEX_OUT, PASS_OUT and LAST_OUT hold stable. No element is skipped or duplicated.
- Ignored inputs in SEND: WRITE_ENABLE and START have no effect.
- Wrap: SIZE_I=1 sets LAST_OUT on every element; PASS_OUT increments on every transfer.
- After DONE: INDEX_OUT and PASS_OUT hold their final values until the next valid START. DATA_OUT follows buffer[INDEX_OUT].
- Counters are CONTROL_SIZE wide; SIZE_R_IN uses the full range with no overflow check.

Test Plan:
- Reset: hold RST=0 for 2 cycles during streaming -> READY=1, DATA_OUT_ENABLE=0, DATA_OUT=0, ERROR=0, DONE=0; a subsequent SIZE_I=2, SIZE_R=1 stream outputs 0,0.
- Basic stream: write [1,2,3,4] at indices 0..3; START with SIZE_I=4, SIZE_R=2; DATA_IN_ENABLE=1 -> 8 back-to-back transfers 1,2,3,4,1,2,3,4; PASS_OUT 0,0,0,0,1,1,1,1; LAST_OUT on the 4th and 8th; DONE pulses the cycle after the 8th, with READY=1.
- Backpressure: same setup; drop DATA_IN_ENABLE for 3 cycles while element 3 (index 2) is presented -> DATA_OUT=3, INDEX_OUT=2 stable for the stall; sequence intact; total busy time 11 cycles.
- Invalid start: START with SIZE_I=0, then SIZE_I=65, then SIZE_R=0 -> ERROR=1 each time, no DATA_OUT_ENABLE, READY=1; a following START with SIZE_I=1, SIZE_R=3 clears ERROR and sends buffer[0] 3 times with LAST_OUT=1 each time.
- Full length: write buffer[i]=i+100 for i=0..63; START with SIZE_I=64, SIZE_R=1; write index 0 with 0xFF during SEND -> outputs 100..163, last element INDEX_OUT=63 with LAST_OUT=1; buffer[0] is still 100 afterwards.
- Reset mid-operation: after 3 of 8 transfers, RST=0 for one cycle -> next cycle IDLE, all outputs at reset values, no DONE pulse.

Source files
------------

// File: rtl/model_convolutional_fnn_vector_transmitter.sv
// Source-side vector streamer: buffers one input vector, then replays it
// SIZE_R times (SIZE_I elements per pass) over a valid/accept element handshake.
module model_convolutional_fnn_vector_transmitter #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int LENGTH       = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    WRITE_ENABLE,
    input  logic [CONTROL_SIZE-1:0] WRITE_INDEX,
    input  logic [DATA_SIZE-1:0]    WRITE_DATA,
    input  logic                    START,
    input  logic [CONTROL_SIZE-1:0] SIZE_I_IN,
    input  logic [CONTROL_SIZE-1:0] SIZE_R_IN,
    output logic                    READY,
    output logic                    DONE,
    output logic                    ERROR,
    output logic                    DATA_OUT_ENABLE,
    input  logic                    DATA_IN_ENABLE,
    output logic [DATA_SIZE-1:0]    DATA_OUT,
    output logic [CONTROL_SIZE-1:0] INDEX_OUT,
    output logic [CONTROL_SIZE-1:0] PASS_OUT,
    output logic                    LAST_OUT
);

    localparam int ADDR_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [CONTROL_SIZE-1:0] LENGTH_C = CONTROL_SIZE'(LENGTH);
    localparam logic [CONTROL_SIZE-1:0] ONE_C    = {{(CONTROL_SIZE-1){1'b0}}, 1'b1};
    localparam logic [CONTROL_SIZE-1:0] ZERO_C   = {CONTROL_SIZE{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                  state_q,  state_d;
    logic [CONTROL_SIZE-1:0] size_i_q, size_i_d;
    logic [CONTROL_SIZE-1:0] size_r_q, size_r_d;
    logic [CONTROL_SIZE-1:0] index_q,  index_d;
    logic [CONTROL_SIZE-1:0] pass_q,   pass_d;
    logic                    error_q,  error_d;
    logic                    done_q,   done_d;
    logic [DATA_SIZE-1:0]    buf_q [LENGTH];
    logic [DATA_SIZE-1:0]    buf_d [LENGTH];

    logic write_ok_s;
    logic start_ok_s;
    logic xfer_s;
    logic last_elem_s;
    logic last_pass_s;

    // Handshake and boundary decodes shared by the next-state and output logic
    always_comb begin
        write_ok_s  = (state_q == ST_IDLE) && WRITE_ENABLE && (WRITE_INDEX < LENGTH_C);
        start_ok_s  = (SIZE_I_IN != ZERO_C) && (SIZE_I_IN <= LENGTH_C) && (SIZE_R_IN != ZERO_C);
        xfer_s      = (state_q == ST_SEND) && DATA_IN_ENABLE;
        last_elem_s = (index_q == (size_i_q - ONE_C));
        last_pass_s = (pass_q == (size_r_q - ONE_C));
    end

    // Buffer update: writes land only while idle, so a same-cycle START streams the new data
    always_comb begin
        buf_d = buf_q;
        if (write_ok_s) begin
            buf_d[WRITE_INDEX[ADDR_W-1:0]] = WRITE_DATA;
        end else begin
            buf_d = buf_q;
        end
    end

    // Next-state and counter logic; on the final transfer the counters keep their last values
    always_comb begin
        state_d  = state_q;
        size_i_d = size_i_q;
        size_r_d = size_r_q;
        index_d  = index_q;
        pass_d   = pass_q;
        error_d  = error_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (start_ok_s) begin
                        state_d  = ST_SEND;
                        size_i_d = SIZE_I_IN;
                        size_r_d = SIZE_R_IN;
                        index_d  = ZERO_C;
                        pass_d   = ZERO_C;
                        error_d  = 1'b0;
                    end else begin
                        error_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (xfer_s) begin
                    if (!last_elem_s) begin
                        index_d = index_q + ONE_C;
                    end else if (!last_pass_s) begin
                        index_d = ZERO_C;
                        pass_d  = pass_q + ONE_C;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and buffer registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            size_i_q <= ZERO_C;
            size_r_q <= ZERO_C;
            index_q  <= ZERO_C;
            pass_q   <= ZERO_C;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < LENGTH; i++) begin
                buf_q[i] <= {DATA_SIZE{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            size_i_q <= size_i_d;
            size_r_q <= size_r_d;
            index_q  <= index_d;
            pass_q   <= pass_d;
            error_q  <= error_d;
            done_q   <= done_d;
            buf_q    <= buf_d;
        end
    end

    // Output decode from registered state; DATA_OUT tracks buffer[INDEX_OUT] in every state
    always_comb begin
        READY           = (state_q == ST_IDLE);
        DATA_OUT_ENABLE = (state_q == ST_SEND);
        DONE            = done_q;
        ERROR           = error_q;
        DATA_OUT        = buf_q[index_q[ADDR_W-1:0]];
        INDEX_OUT       = index_q;
        PASS_OUT        = pass_q;
        LAST_OUT        = (state_q == ST_SEND) && last_elem_s;
    end

endmodule

// File: tb/tb_model_convolutional_fnn_vector_transmitter.sv
// Directed bench for the vector transmitter: a scoreboard of expected elements
// is filled at START and drained as the DUT presents each element.
module tb_model_convolutional_fnn_vector_transmitter;

    logic        CLK;
    logic        RST;
    logic        WRITE_ENABLE;
    logic [63:0] WRITE_INDEX;
    logic [63:0] WRITE_DATA;
    logic        START;
    logic [63:0] SIZE_I_IN;
    logic [63:0] SIZE_R_IN;
    logic        READY;
    logic        DONE;
    logic        ERROR;
    logic        DATA_OUT_ENABLE;
    logic        DATA_IN_ENABLE;
    logic [63:0] DATA_OUT;
    logic [63:0] INDEX_OUT;
    logic [63:0] PASS_OUT;
    logic        LAST_OUT;

    typedef struct {
        logic [63:0] data;
        logic [63:0] idx;
        logic [63:0] pass;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model_buf [64];
    int          checks = 0;
    int          errors = 0;
    int          busy;

    model_convolutional_fnn_vector_transmitter #(
        .DATA_SIZE(64), .CONTROL_SIZE(64), .LENGTH(64)
    ) dut (
        .CLK(CLK), .RST(RST),
        .WRITE_ENABLE(WRITE_ENABLE), .WRITE_INDEX(WRITE_INDEX), .WRITE_DATA(WRITE_DATA),
        .START(START), .SIZE_I_IN(SIZE_I_IN), .SIZE_R_IN(SIZE_R_IN),
        .READY(READY), .DONE(DONE), .ERROR(ERROR),
        .DATA_OUT_ENABLE(DATA_OUT_ENABLE), .DATA_IN_ENABLE(DATA_IN_ENABLE),
        .DATA_OUT(DATA_OUT), .INDEX_OUT(INDEX_OUT), .PASS_OUT(PASS_OUT), .LAST_OUT(LAST_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_buf(input int idx, input logic [63:0] data);
        WRITE_ENABLE = 1'b1;
        WRITE_INDEX  = 64'(idx);
        WRITE_DATA   = data;
        step();
        WRITE_ENABLE = 1'b0;
        if (idx < 64) model_buf[idx] = data;
    endtask

    task automatic start(input int si, input int sr);
        SIZE_I_IN = 64'(si);
        SIZE_R_IN = 64'(sr);
        START     = 1'b1;
        step();
        START     = 1'b0;
    endtask

    task automatic push_stream(input int si, input int sr);
        exp_t e;
        for (int p = 0; p < sr; p++) begin
            for (int i = 0; i < si; i++) begin
                e.data = model_buf[i];
                e.idx  = 64'(i);
                e.pass = 64'(p);
                e.last = (i == si - 1);
                sb.push_back(e);
            end
        end
    endtask

    // Present/accept n_xfer elements; stall for stall_n cycles before transfer number stall_at
    task automatic drain(input int n_xfer, input int stall_at, input int stall_n, output int cycles);
        int   done_n  = 0;
        int   stalled = 0;
        exp_t e;
        cycles = 0;
        while (done_n < n_xfer) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_empty: observed 0 entries expected %0d more", n_xfer - done_n);
                break;
            end
            e = sb[0];
            check("doe",   64'(DATA_OUT_ENABLE), 64'd1);
            check("data",  DATA_OUT,  e.data);
            check("index", INDEX_OUT, e.idx);
            check("pass",  PASS_OUT,  e.pass);
            check("last",  64'(LAST_OUT), 64'(e.last));
            if (done_n == stall_at && stalled < stall_n) begin
                DATA_IN_ENABLE = 1'b0;
                stalled++;
            end else begin
                DATA_IN_ENABLE = 1'b1;
                void'(sb.pop_front());
                done_n++;
            end
            step();
            cycles++;
        end
        DATA_IN_ENABLE = 1'b0;
    endtask

    task automatic finish_check();
        check("done_pulse",  64'(DONE), 64'd1);
        check("done_ready",  64'(READY), 64'd1);
        check("done_doe",    64'(DATA_OUT_ENABLE), 64'd0);
        step();
        check("done_single", 64'(DONE), 64'd0);
    endtask

    initial begin
        RST = 1'b0; WRITE_ENABLE = 1'b0; WRITE_INDEX = 64'd0; WRITE_DATA = 64'd0;
        START = 1'b0; SIZE_I_IN = 64'd0; SIZE_R_IN = 64'd0; DATA_IN_ENABLE = 1'b0;
        for (int i = 0; i < 64; i++) model_buf[i] = 64'd0;

        // Power-on reset
        step(); step();
        RST = 1'b1;
        check("rst_ready", 64'(READY), 64'd1);
        check("rst_doe",   64'(DATA_OUT_ENABLE), 64'd0);
        check("rst_data",  DATA_OUT, 64'd0);
        check("rst_error", 64'(ERROR), 64'd0);
        check("rst_done",  64'(DONE), 64'd0);
        check("rst_index", INDEX_OUT, 64'd0);
        check("rst_pass",  PASS_OUT, 64'd0);
        check("rst_last",  64'(LAST_OUT), 64'd0);

        // Basic stream 1,2,3,4 twice
        for (int i = 0; i < 4; i++) write_buf(i, 64'(i + 1));
        start(4, 2);
        push_stream(4, 2);
        check("basic_ready_low", 64'(READY), 64'd0);
        drain(8, -1, 0, busy);
        check("basic_busy", 64'(busy), 64'd8);
        finish_check();

        // Backpressure on the third element
        start(4, 2);
        push_stream(4, 2);
        drain(8, 2, 3, busy);
        check("bp_busy", 64'(busy), 64'd11);
        finish_check();

        // Invalid starts
        start(0, 1);
        check("inv0_error", 64'(ERROR), 64'd1);
        check("inv0_doe",   64'(DATA_OUT_ENABLE), 64'd0);
        check("inv0_ready", 64'(READY), 64'd1);
        start(65, 1);
        check("inv65_error", 64'(ERROR), 64'd1);
        check("inv65_doe",   64'(DATA_OUT_ENABLE), 64'd0);
        start(4, 0);
        check("invr0_error", 64'(ERROR), 64'd1);
        check("invr0_ready", 64'(READY), 64'd1);
        start(1, 3);
        push_stream(1, 3);
        check("valid_clears_error", 64'(ERROR), 64'd0);
        drain(3, -1, 0, busy);
        finish_check();

        // Full-length buffer; a write during SEND must be ignored
        for (int i = 0; i < 64; i++) write_buf(i, 64'(i + 100));
        start(64, 1);
        push_stream(64, 1);
        WRITE_ENABLE = 1'b1; WRITE_INDEX = 64'd0; WRITE_DATA = 64'hFF;
        drain(64, -1, 0, busy);
        WRITE_ENABLE = 1'b0;
        check("full_hold_index", INDEX_OUT, 64'd63);
        check("full_hold_pass",  PASS_OUT, 64'd0);
        check("full_hold_data",  DATA_OUT, 64'd163);
        finish_check();
        start(1, 1);
        push_stream(1, 1);
        drain(1, -1, 0, busy);
        finish_check();

        // Reset after 3 of 8 transfers
        start(4, 2);
        push_stream(4, 2);
        drain(3, -1, 0, busy);
        RST = 1'b0;
        step();
        RST = 1'b1;
        sb.delete();
        for (int i = 0; i < 64; i++) model_buf[i] = 64'd0;
        check("mid_rst_ready", 64'(READY), 64'd1);
        check("mid_rst_doe",   64'(DATA_OUT_ENABLE), 64'd0);
        check("mid_rst_data",  DATA_OUT, 64'd0);
        check("mid_rst_index", INDEX_OUT, 64'd0);
        check("mid_rst_pass",  PASS_OUT, 64'd0);
        check("mid_rst_last",  64'(LAST_OUT), 64'd0);
        check("mid_rst_done",  64'(DONE), 64'd0);
        step();
        check("mid_rst_no_done", 64'(DONE), 64'd0);
        check("mid_rst_error",   64'(ERROR), 64'd0);

        // Cleared buffer streams zeros
        start(2, 1);
        push_stream(2, 1);
        drain(2, -1, 0, busy);
        finish_check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
